// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: base opcodes, operation classes and the
// decoded record passed from decode to execute.
package rv32i_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        OC_ALUREG, OC_ALUIMM, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL,
        OC_JALR, OC_LUI, OC_AUIPC, OC_FENCE, OC_SYSTEM, OC_NONE
    } op_class_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        op_class_e   op_class;
        logic        is_alu_reg;
        logic        illegal;
    } decoded_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Sign-extended immediate extraction by instruction format (I/S/B/U/J);
// formats without an immediate (R-type, unknown opcodes) yield zero.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR, MISC_MEM, SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:
                imm = {instr[31:12], 12'b0};
            JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: decodes on entry into a two-entry skid buffer so that
// in_ready comes straight from a flop and never from out_ready.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output op_class_e   op_class,
    output logic        is_alu_reg,
    output logic        illegal
);

    localparam decoded_t RST_REC = '{pc: RESET_PC, op_class: OC_NONE, default: '0};

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_w;
    logic        bad;
    op_class_e   cls;
    decoded_t    dec;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    rv32i_imm_gen u_imm (
        .instr (in_instr),
        .imm   (imm_w)
    );

    always_comb begin
        bad = 1'b0;
        cls = OC_NONE;
        case (opc)
            OP: begin
                cls = OC_ALUREG;
                bad = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_IMM: begin
                cls = OC_ALUIMM;
                bad = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            LOAD: begin
                cls = OC_LOAD;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            STORE: begin
                cls = OC_STORE;
                bad = (f3 > 3'b010);
            end
            BRANCH: begin
                cls = OC_BRANCH;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            JAL:      cls = OC_JAL;
            JALR: begin
                cls = OC_JALR;
                bad = (f3 != 3'b000);
            end
            LUI:      cls = OC_LUI;
            AUIPC:    cls = OC_AUIPC;
            MISC_MEM: cls = OC_FENCE;
            SYSTEM:   cls = OC_SYSTEM;
            default:  bad = 1'b1;
        endcase
        // Compressed/non-32-bit encodings never reach a legal opcode, kept explicit.
        if (in_instr[1:0] != 2'b11) bad = 1'b1;
    end

    always_comb begin
        dec            = RST_REC;
        dec.pc         = in_pc;
        dec.rs1        = in_instr[19:15];
        dec.rs2        = in_instr[24:20];
        dec.rd         = in_instr[11:7];
        dec.funct3     = f3;
        dec.funct7     = f7;
        dec.imm        = imm_w;
        dec.op_class   = bad ? OC_NONE : cls;
        dec.is_alu_reg = (opc == OP);
        dec.illegal    = bad;
    end

    decoded_t m_q, s_q;
    logic     m_vld, s_vld;
    logic     acc, cons;

    assign in_ready = !s_vld;
    assign acc      = in_valid && in_ready;
    assign cons     = m_vld && out_ready;

    // S only fills while M is held, so the pair always drains M first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q   <= RST_REC;
            s_q   <= RST_REC;
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (cons) begin
            if (s_vld) begin
                m_q   <= s_q;
                s_vld <= 1'b0;
            end else if (acc) begin
                m_q   <= dec;
            end else begin
                m_vld <= 1'b0;
            end
        end else if (acc) begin
            if (!m_vld) begin
                m_q   <= dec;
                m_vld <= 1'b1;
            end else begin
                s_q   <= dec;
                s_vld <= 1'b1;
            end
        end
    end

    assign out_valid  = m_vld;
    assign out_pc     = m_q.pc;
    assign rs1_addr   = m_q.rs1;
    assign rs2_addr   = m_q.rs2;
    assign rd_addr    = m_q.rd;
    assign funct3     = m_q.funct3;
    assign funct7     = m_q.funct7;
    assign imm        = m_q.imm;
    assign op_class   = m_q.op_class;
    assign is_alu_reg = m_q.is_alu_reg;
    assign illegal    = m_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed cases plus randomized traffic checked
// against a queue-based FIFO model and a field-arithmetic decode model.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, is_alu_reg, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    op_class_e   op_class;

    rv32i_decode_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .funct3(funct3), .funct7(funct7), .imm(imm), .op_class(op_class),
        .is_alu_reg(is_alu_reg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    decoded_t dut_rec;
    always_comb dut_rec = {out_pc, rs1_addr, rs2_addr, rd_addr, funct3, funct7,
                           imm, op_class, is_alu_reg, illegal};

    decoded_t rst_rec;
    decoded_t mq[$];
    decoded_t shown;

    function automatic logic [31:0] sx(input longint v, input int bits);
        longint r = v;
        if ((v >> (bits - 1)) & 1) r = v - (longint'(1) << bits);
        return 32'(r);
    endfunction

    function automatic decoded_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        decoded_t    d;
        longint      u = longint'(w);
        int          op = int'(w & 32'h7f);
        int          f3 = int'((w >> 12) & 7);
        int          f7 = int'(w >> 25);
        logic        bad = 1'b0;
        op_class_e   c = OC_NONE;
        logic [31:0] iv = '0;
        case (op)
            'h33: begin c = OC_ALUREG; bad = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))); end
            'h13: begin c = OC_ALUIMM; iv = sx(u >> 20, 12);
                        bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20); end
            'h03: begin c = OC_LOAD;   iv = sx(u >> 20, 12); bad = (f3 == 3 || f3 >= 6); end
            'h23: begin c = OC_STORE;  iv = sx((u >> 25) * 32 + ((u >> 7) & 31), 12); bad = f3 > 2; end
            'h63: begin c = OC_BRANCH; bad = (f3 == 2 || f3 == 3);
                        iv = sx(((u >> 31) << 12) + (((u >> 7) & 1) << 11) +
                                (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1), 13); end
            'h6f: begin c = OC_JAL;
                        iv = sx(((u >> 31) << 20) + (((u >> 12) & 255) << 12) +
                                (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1), 21); end
            'h67: begin c = OC_JALR;   iv = sx(u >> 20, 12); bad = f3 != 0; end
            'h37: begin c = OC_LUI;    iv = w & 32'hFFFF_F000; end
            'h17: begin c = OC_AUIPC;  iv = w & 32'hFFFF_F000; end
            'h0f: begin c = OC_FENCE;  iv = sx(u >> 20, 12); end
            'h73: begin c = OC_SYSTEM; iv = sx(u >> 20, 12); end
            default: bad = 1'b1;
        endcase
        d.pc         = pc;
        d.rs1        = 5'((w >> 15) & 31);
        d.rs2        = 5'((w >> 20) & 31);
        d.rd         = 5'((w >> 7) & 31);
        d.funct3     = 3'(f3);
        d.funct7     = 7'(f7);
        d.imm        = iv;
        d.op_class   = bad ? OC_NONE : c;
        d.is_alu_reg = (op == 'h33);
        d.illegal    = bad;
        return d;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops [0:10];
        logic [31:0] w;
        int          r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
        r = int'($urandom_range(0, 13));
        w = $urandom;
        if (r < 11) begin
            w[6:0] = ops[r];
            if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    task automatic chk_state();
        chk("in_ready", in_ready, mq.size() < 2);
        chk("out_valid", out_valid, mq.size() > 0);
        chk("record", dut_rec, shown);
    endtask

    // Drives one cycle from a negedge, advances the model, checks at the next negedge.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic acc, cons;
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        acc  = v && (mq.size() < 2);
        cons = (mq.size() > 0) && ordy;
        if (fl) mq.delete();
        else begin
            if (cons) void'(mq.pop_front());
            if (acc) mq.push_back(ref_dec(w, pc));
        end
        @(posedge clk);
        @(negedge clk);
        if (mq.size() > 0) shown = mq[0];
        chk_state();
    endtask

    initial begin
        rst_rec = '0;
        rst_rec.pc = RPC;
        rst_rec.op_class = OC_NONE;
        shown = rst_rec;

        repeat (2) @(negedge clk);
        chk_state();
        resetn = 1'b1;
        @(negedge clk);
        chk_state();

        step(1'b1, 32'hFFF10093, 32'h100, 1'b1, 1'b0);
        chk("addi_rd", rd_addr, 5'd1);
        chk("addi_rs1", rs1_addr, 5'd2);
        chk("addi_f3", funct3, 3'd0);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_cls", op_class, OC_ALUIMM);
        chk("addi_alureg", is_alu_reg, 1'b0);
        chk("addi_ill", illegal, 1'b0);

        step(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
        chk("sub_f7", funct7, 7'h20);
        chk("sub_alureg", is_alu_reg, 1'b1);
        chk("sub_imm", imm, 32'h0);
        chk("sub_ill", illegal, 1'b0);

        step(1'b1, 32'h00512423, 32'h108, 1'b1, 1'b0);
        chk("sw_cls", op_class, OC_STORE);
        chk("sw_rs1", rs1_addr, 5'd2);
        chk("sw_rs2", rs2_addr, 5'd5);
        chk("sw_imm", imm, 32'd8);

        step(1'b1, 32'h0000_0000, 32'h10C, 1'b1, 1'b0);
        chk("zero_ill", illegal, 1'b1);
        chk("zero_cls", op_class, OC_NONE);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: third word waits until S drains.
        step(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
        chk("bp_ready_low", in_ready, 1'b0);
        step(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
        chk("bp_hold_pc", out_pc, 32'h200);
        step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
        chk("bp_out2", out_pc, 32'h204);
        step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
        chk("bp_out3", out_pc, 32'h208);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_empty", out_valid, 1'b0);

        // Flush with both entries full and a new word offered.
        step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 32'hDEAD_0000, 1'b0, 1'b1);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ready", in_ready, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        step(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_rec", dut_rec, rst_rec);
        mq.delete();
        shown = rst_rec;
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 32'hFFF10093, 32'h500, 1'b1, 1'b0);
        chk("post_rst_pc", out_pc, 32'h500);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, rnd_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Pipelined RV32I instruction decoder between fetch and the ALU/execute stage. It accepts 32-bit instruction words with their PC over a valid/ready handshake. It produces the register addresses, funct3/funct7, the sign-extended immediate, the operand-select flags and an illegal-instruction flag that the ALU and the rest of execute consume. A two-entry skid buffer keeps `in_ready` registered, so back-pressure never forms a combinational path from execute to fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value driven on `out_pc` while empty and after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all buffered instructions.
- `in_valid`  in  1  fetch offers `in_instr` / `in_pc`.
- `in_ready`  out  1  decoder can accept a word this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `out_valid`  out  1  decoded record is present.
- `out_ready`  in  1  execute consumes the record.
- `out_pc`  out  32  PC of the decoded instruction.
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  register indices from bits [19:15], [24:20], [11:7].
- `funct3`  out  3  instruction bits [14:12].
- `funct7`  out  7  instruction bits [31:25].
- `imm`  out  32  sign-extended immediate for the instruction format (I/S/B/U/J); 0 for R-type.
- `op_class`  out  4  `op_class_e` encoding: ALUREG, ALUIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, NONE.
- `is_alu_reg`  out  1  second ALU operand is rs2 (opcode 0110011).
- `illegal`  out  1  word is not a valid RV32I encoding.

## Operation
- Entries are held as `decoded_t` records, and decode happens on entry write. Each record's fields are computed combinationally from `in_instr` and registered.
- Storage:
  - Main register M drives the outputs.
  - Skid register S holds one extra record.
  - `out_valid` = M valid.
  - `in_ready` = !S valid (registered).
- Accept: when `in_valid && in_ready`, the new record goes to M if M is empty or is being consumed this cycle and S is empty. Otherwise it goes to S.
- Consume: when `out_valid && out_ready`, M is loaded from S if S is valid, else from the accepted input if any, else M becomes empty.
- Order is strictly FIFO. No record is lost or duplicated.
- Illegal rules, any of which sets `illegal`:
  - `in_instr[1:0] != 2'b11`.
  - Opcode not in the RV32I set.
  - OP: funct7 is not 0000000/0100000, or funct7 = 0100000 with funct3 not in {000, 101}.
  - OP-IMM shift: funct3 = 001 with funct7 != 0, or funct3 = 101 with funct7 not in {0000000, 0100000}.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 > 010.
  - BRANCH funct3 in {010, 011}.
  - JALR funct3 != 000.
  - An illegal word still produces a record with `op_class` = NONE.
- Flush: both entries are invalidated at the edge.
  - If `in_valid` is high in the same cycle as `flush`, that input is dropped.
  - Flush wins over simultaneous accept and consume.
- Output fields when `out_valid` = 0:
  - Hold their last values.
  - After reset: all zero, `out_pc` = `RESET_PC`, `op_class` = NONE.

## Timing
- Latency: an input accepted at edge N is visible on the outputs after edge N when M was free. Otherwise it appears one cycle after the older record is consumed.
- Throughput: one instruction per cycle with `out_ready` held high.
- `in_ready` falls the cycle after S fills and rises the cycle after S drains. No combinational path exists from `out_ready` to `in_ready`.
- Reset values: `in_ready` = 1, `out_valid` = 0, all other outputs as stated above. Reset asserted mid-stream empties both entries immediately, asynchronously, with no partial state.
- When `out_valid` = 1 and `out_ready` = 0, all outputs are stable until consumed.

## Structure
- Package `rv32i_pkg` holds:
  - Opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM).
  - `op_class_e` enum.
  - `decoded_t` packed struct (pc, rs1/rs2/rd, funct3, funct7, imm, op_class, is_alu_reg, illegal).
- One sub-module `rv32i_imm_gen`: combinational immediate extraction per format. It is shared with future branch/jump target logic.
- The skid buffer stays inline in this block.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093), outputs idle → one cycle later:
  - `rd_addr` = 1, `rs1_addr` = 2, `funct3` = 0.
  - `imm` = 0xFFFF_FFFF, `op_class` = ALUIMM, `is_alu_reg` = 0, `illegal` = 0.
- SUB x3,x1,x2 (0x402081B3) → `funct7` = 0x20, `is_alu_reg` = 1, `imm` = 0, `illegal` = 0.
- SW x5,8(x2) (0x00512423) → `op_class` = STORE, `rs1_addr` = 2, `rs2_addr` = 5, `imm` = 8. Then 0x00000000 → `illegal` = 1, `op_class` = NONE.
- Back-pressure: stream three instructions with `out_ready` = 0.
  - Two are accepted and `in_ready` drops.
  - Raise `out_ready`: all three emerge in order on consecutive cycles, none duplicated.
- Flush while both entries are full and `in_valid` = 1:
  - Next cycle `out_valid` = 0 and `in_ready` = 1.
  - The flushed-cycle input never appears.
- Assert `resetn` = 0 mid-stream between clock edges → `out_valid` = 0 immediately, outputs zero, `out_pc` = `RESET_PC`. Decoding resumes cleanly after release.
